ram_1port_arb: RTL
==================

Name: ram_1port_arb

Overview:
- Shares one single-port RAM (addr/wr_data/rd_data/wr_en, 1-cycle read, no output register) between two requesters, A and B.
- Arbitration is round-robin. Each requester uses a valid/ready handshake and gets read data back tagged with rvalid.
- After reset, an optional init sweep writes INIT_VALUE to every address before traffic is accepted.
- Sits directly in front of the RAM instance; all RAM-side outputs are registered.

Parameters:
ADDR_WIDTH, 5, RAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 8, RAM data width
RD_LATENCY, 1, RAM read latency in clk cycles (legal 1 or 2; 2 when the RAM output register is enabled)
INIT_CLEAR, 1, 1 = run init sweep after reset; 0 = go straight to RUN
INIT_VALUE, 0, data written during the init sweep

Ports:
clk  input  1  single clock; everything is on the rising edge
rst  input  1  synchronous active-high reset
a_valid  input  1  requester A command valid
a_we  input  1  A: 1 = write, 0 = read
a_addr  input  ADDR_WIDTH  A address
a_wdata  input  DATA_WIDTH  A write data
a_ready  output  1  A command accepted this cycle
a_rvalid  output  1  A read data valid
a_rdata  output  DATA_WIDTH  A read data
b_valid, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata  same as A, for requester B
ram_addr  output  ADDR_WIDTH  to RAM addr
ram_wr_data  output  DATA_WIDTH  to RAM wr_data
ram_wr_en  output  1  to RAM wr_en
ram_rd_data  input  DATA_WIDTH  from RAM rd_data
init_done  output  1  high once RUN is entered
stall_cnt  output  16  saturating count of cycles in RUN where a valid was high but its ready was low

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = INIT if INIT_CLEAR=1, else RUN.
  - init_cnt, ram_addr, ram_wr_data, ram_wr_en, stall_cnt, init_done = 0.
  - Read-tag pipeline is cleared; last_grant = B, so A wins the first contention.
  - a_ready, b_ready, a_rvalid, b_rvalid are 0 during reset and the cycle after.
- Reset mid-operation: in-flight reads are dropped with no rvalid. RAM contents are not restored unless the init sweep reruns.
- FSM states: INIT, RUN. There is no other state.
- INIT:
  - Each cycle: ram_wr_en=1, ram_addr=init_cnt, ram_wr_data=INIT_VALUE; init_cnt increments.
  - After the write to address 2^ADDR_WIDTH-1, state goes to RUN. The sweep is exactly 2^ADDR_WIDTH cycles.
  - a_ready and b_ready stay 0 throughout.
- RUN:
  - init_done=1.
  - Grant is combinational:
    - only one port valid: that port is granted;
    - both valid: the port that is not last_grant is granted;
    - none valid: no grant.
  - x_ready = RUN & grant_x. A transfer happens when x_valid & x_ready.
  - last_grant updates to the granted port on every transfer.
- Issue stage:
  - A transfer at cycle T drives ram_addr, ram_wr_data, ram_wr_en (= x_we) registered during T+1.
  - In a cycle with no transfer: ram_wr_en=0; ram_addr and ram_wr_data hold their previous values.
- Read return:
  - A read accepted at cycle T gives x_rvalid=1 for exactly one cycle, T+1+RD_LATENCY, with x_rdata = ram_rd_data in that cycle.
  - A tag pipeline of depth 1+RD_LATENCY carries the port id and read flag.
  - x_rdata is don't-care when rvalid=0. Writes produce no rvalid.
- Throughput and ordering:
  - One command per cycle in total. Back-to-back reads are fully pipelined.
  - Commands reach the RAM in acceptance order, so a read accepted after a write to the same address returns the new data.
- Requester rule: x_valid and its payload are held until x_ready.
- stall_cnt increments by 1 per cycle for each port with valid & !ready in RUN (+2 when both stall). It saturates at 16'hFFFF and never wraps. Stalls during INIT are not counted.

Test Plan:
- INIT_CLEAR=1, INIT_VALUE=8'hA5, rst 1 cycle, a_valid=1 read addr 0:
  - ram_wr_en=1 for exactly 32 consecutive cycles covering addrs 0..31, then init_done=1;
  - a_ready=0 during the sweep; the read returns a_rdata=8'hA5 two cycles after acceptance.
- Write/read sequence on A, RD_LATENCY=1:
  - A writes addr 3 = 8'h5C, then next cycle reads addr 3;
  - a_rvalid=1 exactly 2 cycles after read acceptance, a_rdata=8'h5C; b_rvalid stays 0.
- Contention, A and B both valid reading addrs 1 and 2 for 4 cycles:
  - grants alternate A,B,A,B;
  - stall_cnt rises by 1 each cycle, ends at 4;
  - rvalids alternate with the matching data.
- Back-to-back B reads of addrs 0..7 with A idle:
  - b_ready=1 every cycle;
  - b_rvalid high for 8 consecutive cycles carrying data in address order.
- rst asserted 1 cycle after A reads addr 4 is accepted:
  - no a_rvalid ever appears;
  - all outputs return to reset values; the sweep restarts at addr 0.
- stall_cnt saturation: preload near max via a long contention run (or force):
  - value holds at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/ram_1port_arb_if.sv
// Requester-side command/response bundle for one port of the shared single-port RAM.
// master = requester, slave = arbiter.
interface ram_1port_arb_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output valid, we, addr, wdata, input  ready, rvalid, rdata);
    modport slave  (input  valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram_1port_arb.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B, with post-reset init sweep.
// Latency: command to RAM pins 1 cycle; read data returns 1+RD_LATENCY cycles after acceptance.
// Backpressure: one command per cycle total; the losing/idle-phase requester sees ready low and must hold.
module ram_1port_arb #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    RD_LATENCY = 1,
    parameter bit                    INIT_CLEAR = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_1port_arb_if.slave        a,
    ram_1port_arb_if.slave        b,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  init_done,
    output logic [15:0]           stall_cnt
);
    localparam int TAG_DEPTH = 1 + RD_LATENCY;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic rd;
        logic port;   // 0 = A, 1 = B
    } tag_t;

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      init_cnt;
    logic                       last_grant_b;
    tag_t [TAG_DEPTH-1:0]       tag_q;

    logic                       grant_a;
    logic                       grant_b;
    logic                       xfer_a;
    logic                       xfer_b;
    logic                       xfer;
    logic                       sel_we;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [DATA_WIDTH-1:0]      sel_wdata;
    tag_t                       new_tag;
    logic                       stall_a;
    logic                       stall_b;
    logic [16:0]                stall_sum;
    logic [15:0]                stall_next;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a.valid && b.valid) begin
            grant_a = last_grant_b;
            grant_b = ~last_grant_b;
        end else begin
            grant_a = a.valid;
            grant_b = b.valid;
        end
    end

    // init_done doubles as "traffic allowed"; rst gates ready so nothing is accepted during reset
    assign a.ready = init_done & ~rst & grant_a;
    assign b.ready = init_done & ~rst & grant_b;

    assign xfer_a    = a.valid & a.ready;
    assign xfer_b    = b.valid & b.ready;
    assign xfer      = xfer_a | xfer_b;
    assign sel_we    = xfer_b ? b.we    : a.we;
    assign sel_addr  = xfer_b ? b.addr  : a.addr;
    assign sel_wdata = xfer_b ? b.wdata : a.wdata;
    assign new_tag   = '{rd: xfer & ~sel_we, port: xfer_b};

    assign stall_a    = init_done & a.valid & ~a.ready;
    assign stall_b    = init_done & b.valid & ~b.ready;
    assign stall_sum  = {1'b0, stall_cnt} + 17'(stall_a) + 17'(stall_b);
    assign stall_next = stall_sum[16] ? 16'hFFFF : stall_sum[15:0];

    assign a.rvalid = ~rst & tag_q[RD_LATENCY].rd & ~tag_q[RD_LATENCY].port;
    assign b.rvalid = ~rst & tag_q[RD_LATENCY].rd &  tag_q[RD_LATENCY].port;
    assign a.rdata  = ram_rd_data;
    assign b.rdata  = ram_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= INIT_CLEAR ? ST_INIT : ST_RUN;
            init_cnt     <= '0;
            ram_addr     <= '0;
            ram_wr_data  <= '0;
            ram_wr_en    <= 1'b0;
            stall_cnt    <= '0;
            init_done    <= 1'b0;
            last_grant_b <= 1'b1;
            tag_q        <= '0;
        end else begin
            tag_q <= {tag_q[TAG_DEPTH-2:0], new_tag};
            case (state)
                ST_INIT: begin
                    ram_wr_en   <= 1'b1;
                    ram_addr    <= init_cnt;
                    ram_wr_data <= INIT_VALUE;
                    init_cnt    <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done <= 1'b1;
                    stall_cnt <= stall_next;
                    ram_wr_en <= xfer & sel_we;
                    if (xfer) begin
                        ram_addr     <= sel_addr;
                        ram_wr_data  <= sel_wdata;
                        last_grant_b <= xfer_b;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end
endmodule
